// File: rtl/proc_ctrl_fsm_p_pkg.sv
// rtl/proc_ctrl_fsm_p_pkg.sv - shared opcode/state types for the bus processor control unit
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_MVNZ = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  // S_HALT is the retire cycle of a halt; S_HALT_HOLD is where the core parks afterwards.
  typedef enum logic [4:0] {
    S_IDLE      = 5'd0,
    S_FETCH_A   = 5'd1,
    S_FETCH_W   = 5'd2,
    S_DECODE    = 5'd3,
    S_MV        = 5'd4,
    S_MVI_A     = 5'd5,
    S_MVI_W     = 5'd6,
    S_ALU1      = 5'd7,
    S_ALU2      = 5'd8,
    S_ALU3      = 5'd9,
    S_LD_A      = 5'd10,
    S_LD_W      = 5'd11,
    S_ST_A      = 5'd12,
    S_ST_D      = 5'd13,
    S_ST_W      = 5'd14,
    S_MVNZ      = 5'd15,
    S_HALT      = 5'd16,
    S_HALT_HOLD = 5'd17
  } state_t;

  // The program counter is always the highest-numbered register.
  function automatic int pc_idx(input int reg_bits);
    return (1 << reg_bits) - 1;
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_p_if.sv
// rtl/proc_ctrl_fsm_p_if.sv - control unit <-> datapath/memory signal bundle
interface proc_ctrl_fsm_p_if #(parameter int REG_BITS = 3);

  localparam int N_REGS = 1 << REG_BITS;
  localparam int IR_W   = 3 + 2 * REG_BITS;

  logic              run;
  logic [IR_W-1:0]   din;
  logic              mem_ready;
  logic              g_nz;
  logic [IR_W-1:0]   ir;
  logic [4:0]        state;
  logic [N_REGS-1:0] reg_in;
  logic [N_REGS-1:0] reg_out;
  logic              g_out;
  logic              din_out;
  logic              a_in;
  logic              g_in;
  logic              add_sub;
  logic              ir_in;
  logic              addr_in;
  logic              dout_in;
  logic              w_d;
  logic              mem_req;
  logic              incr_pc;
  logic              done;

  modport master (
    input  run, din, mem_ready, g_nz,
    output ir, state, reg_in, reg_out, g_out, din_out, a_in, g_in, add_sub, ir_in,
           addr_in, dout_in, w_d, mem_req, incr_pc, done
  );

  modport slave (
    output run, din, mem_ready, g_nz,
    input  ir, state, reg_in, reg_out, g_out, din_out, a_in, g_in, add_sub, ir_in,
           addr_in, dout_in, w_d, mem_req, incr_pc, done
  );

endinterface

// File: rtl/proc_ctrl_fsm_p_reg_sel_decoder.sv
// rtl/proc_ctrl_fsm_p_reg_sel_decoder.sv - register index to gated one-hot select
module reg_sel_decoder #(
  parameter int REG_BITS = 3
) (
  input  logic [REG_BITS-1:0]        idx,
  input  logic                       en,
  output logic [(1 << REG_BITS)-1:0] onehot
);

  localparam int N_REGS = 1 << REG_BITS;

  assign onehot = en ? (N_REGS'(1) << idx) : '0;

endmodule

// File: rtl/proc_ctrl_fsm_p.sv
// rtl/proc_ctrl_fsm_p.sv - multicycle bus processor control FSM, parametrised register count
module proc_ctrl_fsm_p
  import proc_ctrl_pkg::*;
#(
  parameter int REG_BITS = 3
) (
  input logic             clk,
  input logic             resetn,
  proc_ctrl_fsm_p_if.master bus
);

  localparam int N_REGS = 1 << REG_BITS;
  localparam int IR_W   = 3 + 2 * REG_BITS;
  localparam logic [REG_BITS-1:0] PC = REG_BITS'(pc_idx(REG_BITS));

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q;
  logic              nz_q;

  opcode_t           op;
  logic [REG_BITS-1:0] rx, ry;

  logic rx_in_en, rx_out_en, ry_out_en, pc_out_en, ir_load, nz_load;
  logic g_out_s, din_out_s, a_in_s, g_in_s, add_sub_s, addr_in_s;
  logic dout_in_s, w_d_s, mem_req_s, incr_pc_s, done_s;

  logic [N_REGS-1:0] rx_oh, ry_oh, pc_oh;

  assign op = opcode_t'(ir_q[IR_W-1 -: 3]);
  assign rx = ir_q[2*REG_BITS-1 -: REG_BITS];
  assign ry = ir_q[REG_BITS-1:0];

  reg_sel_decoder #(.REG_BITS(REG_BITS)) u_rx_dec (.idx(rx), .en(1'b1),    .onehot(rx_oh));
  reg_sel_decoder #(.REG_BITS(REG_BITS)) u_ry_dec (.idx(ry), .en(ry_out_en), .onehot(ry_oh));
  reg_sel_decoder #(.REG_BITS(REG_BITS)) u_pc_dec (.idx(PC), .en(pc_out_en), .onehot(pc_oh));

  // State, instruction register and the mvnz flag; reset abandons any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= bus.din;
      if (nz_load) nz_q <= bus.g_nz;
    end
  end

  // Next-state and strobe decode; everything defaults to idle so IDLE drives nothing.
  always_comb begin
    state_d   = state_q;
    rx_in_en  = 1'b0;
    rx_out_en = 1'b0;
    ry_out_en = 1'b0;
    pc_out_en = 1'b0;
    ir_load   = 1'b0;
    nz_load   = 1'b0;
    g_out_s   = 1'b0;
    din_out_s = 1'b0;
    a_in_s    = 1'b0;
    g_in_s    = 1'b0;
    add_sub_s = 1'b0;
    addr_in_s = 1'b0;
    dout_in_s = 1'b0;
    w_d_s     = 1'b0;
    mem_req_s = 1'b0;
    incr_pc_s = 1'b0;
    done_s    = 1'b0;

    case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH_A;
      S_FETCH_A: begin
        pc_out_en = 1'b1;
        addr_in_s = 1'b1;
        incr_pc_s = 1'b1;
        state_d   = S_FETCH_W;
      end
      S_FETCH_W: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_MV:          state_d = S_MV;
          OP_MVI:         state_d = S_MVI_A;
          OP_ADD, OP_SUB: state_d = S_ALU1;
          OP_LD:          state_d = S_LD_A;
          OP_ST:          state_d = S_ST_A;
          OP_MVNZ:        state_d = S_MVNZ;
          OP_HALT:        state_d = S_HALT;
          default:        state_d = S_IDLE;
        endcase
      end
      S_MV: begin
        ry_out_en = 1'b1;
        rx_in_en  = 1'b1;
        done_s    = 1'b1;
      end
      S_MVI_A: begin
        pc_out_en = 1'b1;
        addr_in_s = 1'b1;
        state_d   = S_MVI_W;
      end
      S_MVI_W: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          din_out_s = 1'b1;
          rx_in_en  = 1'b1;
          // A load into PC wins over the post-increment.
          incr_pc_s = (rx != PC);
          done_s    = 1'b1;
        end
      end
      S_ALU1: begin
        rx_out_en = 1'b1;
        a_in_s    = 1'b1;
        state_d   = S_ALU2;
      end
      S_ALU2: begin
        ry_out_en = 1'b1;
        g_in_s    = 1'b1;
        add_sub_s = ir_q[IR_W-3];
        state_d   = S_ALU3;
      end
      S_ALU3: begin
        g_out_s  = 1'b1;
        rx_in_en = 1'b1;
        nz_load  = 1'b1;
        done_s   = 1'b1;
      end
      S_LD_A: begin
        ry_out_en = 1'b1;
        addr_in_s = 1'b1;
        state_d   = S_LD_W;
      end
      S_LD_W: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          din_out_s = 1'b1;
          rx_in_en  = 1'b1;
          done_s    = 1'b1;
        end
      end
      S_ST_A: begin
        ry_out_en = 1'b1;
        addr_in_s = 1'b1;
        state_d   = S_ST_D;
      end
      S_ST_D: begin
        rx_out_en = 1'b1;
        dout_in_s = 1'b1;
        state_d   = S_ST_W;
      end
      S_ST_W: begin
        w_d_s     = 1'b1;
        mem_req_s = 1'b1;
        if (bus.mem_ready) done_s = 1'b1;
      end
      S_MVNZ: begin
        ry_out_en = nz_q;
        rx_in_en  = nz_q;
        done_s    = 1'b1;
      end
      S_HALT: begin
        done_s  = 1'b1;
        state_d = bus.run ? S_HALT_HOLD : S_IDLE;
      end
      S_HALT_HOLD: if (!bus.run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ordinary retire: continue fetching while run is held, otherwise park.
    if (done_s && state_q != S_HALT) state_d = bus.run ? S_FETCH_A : S_IDLE;
  end

  assign bus.ir      = ir_q;
  assign bus.state   = state_q;
  assign bus.reg_in  = rx_oh & {N_REGS{rx_in_en}};
  assign bus.reg_out = (rx_oh & {N_REGS{rx_out_en}}) | ry_oh | pc_oh;
  assign bus.g_out   = g_out_s;
  assign bus.din_out = din_out_s;
  assign bus.a_in    = a_in_s;
  assign bus.g_in    = g_in_s;
  assign bus.add_sub = add_sub_s;
  assign bus.ir_in   = ir_load;
  assign bus.addr_in = addr_in_s;
  assign bus.dout_in = dout_in_s;
  assign bus.w_d     = w_d_s;
  assign bus.mem_req = mem_req_s;
  assign bus.incr_pc = incr_pc_s;
  assign bus.done    = done_s;

endmodule
